otter_fetch: RTL and testbench

OTTER_FETCH -- requirements
Module: otter_fetch

---
 rtl/otter_fetch_pkg.sv | 23 ++
 rtl/otter_fetch_pc.sv | 41 ++++
 rtl/otter_fetch.sv | 120 ++++++++++++
 tb/tb_otter_fetch.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/otter_fetch_pkg.sv
// Shared types and constants for the otter fetch unit (state encoding, reset PC, instruction size).
package otter_fetch_pkg;

    typedef enum logic [2:0] {
        ST_BOOT  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_FULL  = 3'd3,
        ST_DRAIN = 3'd4
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] INSTR_BYTES      = 32'd4;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/otter_fetch_pc.sv
// Fetch program counter: redirect load has priority over the sequential increment.
module otter_fetch_pc
    import otter_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load_i,
    input  logic [31:0] load_pc_i,
    input  logic        inc_i,
    output logic [31:0] pc_o
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    // Next-pc select; the add wraps naturally at 2^32
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = word_align(load_pc_i);
        end else if (inc_i) begin
            pc_d = pc_q + INSTR_BYTES;
        end else begin
            pc_d = pc_q;
        end
    end

    // PC register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/otter_fetch.sv
// Instruction fetch unit: one outstanding memory request, result held in an instruction register.
// Optional macro FETCH_ALIGN_CHK_EN rejects misaligned redirects and pulses misalign.
module otter_fetch
    import otter_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        CLK,
    input  logic        RST_N,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic [31:0] ir,
    output logic [31:0] ir_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
`ifdef FETCH_ALIGN_CHK_EN
    ,
    output logic        misalign
`endif
);

    fetch_state_e state_q;
    fetch_state_e state_d;
    logic         req_q;
    logic         ir_valid_q;
    logic [31:0]  ir_q;
    logic [31:0]  ir_pc_q;
    logic [31:0]  pc_s;
    logic         redir_take_s;
    logic         pc_inc_s;

`ifdef FETCH_ALIGN_CHK_EN
    logic redir_bad_s;
    logic misalign_q;

    assign redir_bad_s  = redirect_valid & ~is_word_aligned(redirect_pc);
    assign redir_take_s = redirect_valid & ~redir_bad_s;
    assign misalign     = misalign_q;

    // One-cycle pulse for a rejected redirect
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= redir_bad_s;
        end
    end
`else
    assign redir_take_s = redirect_valid;
`endif

    // A response only lands in ir when no redirect competes with it
    assign pc_inc_s = (state_q == ST_WAIT) & imem_rvalid & ~redir_take_s;

    otter_fetch_pc #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk_i     (CLK),
        .rst_ni    (RST_N),
        .load_i    (redir_take_s),
        .load_pc_i (redirect_pc),
        .inc_i     (pc_inc_s),
        .pc_o      (pc_s)
    );

    // Next-state logic; a redirect out of WAIT must still swallow the in-flight response
    always_comb begin
        state_d = state_q;
        if (redir_take_s) begin
            case (state_q)
                ST_WAIT:  state_d = imem_rvalid ? ST_ISSUE : ST_DRAIN;
                ST_DRAIN: state_d = ST_DRAIN;
                default:  state_d = ST_ISSUE;
            endcase
        end else begin
            case (state_q)
                ST_BOOT:  state_d = ST_ISSUE;
                ST_ISSUE: state_d = ST_WAIT;
                ST_WAIT:  state_d = imem_rvalid ? ST_FULL : ST_WAIT;
                ST_FULL:  state_d = ir_ready ? ST_ISSUE : ST_FULL;
                ST_DRAIN: state_d = imem_rvalid ? ST_ISSUE : ST_DRAIN;
                default:  state_d = ST_BOOT;
            endcase
        end
    end

    // FSM state, request pulse and instruction register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_BOOT;
            req_q      <= 1'b0;
            ir_valid_q <= 1'b0;
            ir_q       <= 32'h0000_0000;
            ir_pc_q    <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            req_q   <= (state_d == ST_ISSUE);
            if (pc_inc_s) begin
                ir_q       <= imem_rdata;
                ir_pc_q    <= pc_s;
                ir_valid_q <= 1'b1;
            end else if (redir_take_s || ((state_q == ST_FULL) && ir_ready)) begin
                ir_valid_q <= 1'b0;
            end else begin
                ir_valid_q <= ir_valid_q;
            end
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = pc_s;
    assign ir_valid  = ir_valid_q;
    assign ir        = ir_q;
    assign ir_pc     = ir_pc_q;

endmodule

// File: tb/tb_otter_fetch.sv
// Bench for otter_fetch: directed scenarios, a flag-level fetch model checked every cycle, literal spot checks.
module tb_otter_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        CLK;
    logic        RST_N;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        ir_valid;
    logic        ir_ready;
    logic [31:0] ir;
    logic [31:0] ir_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef FETCH_ALIGN_CHK_EN
    logic        misalign;
`endif

    int vecs = 0;
    int errs = 0;
    int lat  = 1;

    otter_fetch #(.RESET_PC(RST_PC)) dut (
        .CLK            (CLK),
        .RST_N          (RST_N),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .ir_valid       (ir_valid),
        .ir_ready       (ir_ready),
        .ir             (ir),
        .ir_pc          (ir_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef FETCH_ALIGN_CHK_EN
        ,
        .misalign       (misalign)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0000_0000) ? 32'h0050_0093 : (a ^ 32'h1357_9BDF);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: a live request outstanding, a stale response to discard, or an instruction held
    logic [31:0] m_pc, m_ir, m_ir_pc;
    logic        m_irv, m_req, m_out, m_drop, m_boot;
`ifdef FETCH_ALIGN_CHK_EN
    logic        m_mis;
`endif

    task automatic model_reset();
        m_pc = RST_PC; m_ir = 32'h0; m_ir_pc = 32'h0;
        m_irv = 1'b0; m_req = 1'b0; m_out = 1'b0; m_drop = 1'b0; m_boot = 1'b1;
`ifdef FETCH_ALIGN_CHK_EN
        m_mis = 1'b0;
`endif
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge CLK or negedge RST_N);
            if (!RST_N) begin
                model_reset();
            end else begin
                logic take;
                take = redirect_valid;
`ifdef FETCH_ALIGN_CHK_EN
                m_mis = redirect_valid && (redirect_pc[1:0] != 2'b00);
                if (m_mis) take = 1'b0;
`endif
                if (take) begin
                    m_pc  = {redirect_pc[31:2], 2'b00};
                    m_irv = 1'b0;
                    if (m_out) begin
                        m_out  = 1'b0;
                        m_drop = !imem_rvalid;
                        m_req  = imem_rvalid;
                    end else if (m_drop) begin
                        m_req = 1'b0;
                    end else begin
                        m_req  = 1'b1;
                        m_boot = 1'b0;
                    end
                end else if (m_boot) begin
                    m_boot = 1'b0;
                    m_req  = 1'b1;
                end else if (m_req) begin
                    m_req = 1'b0;
                    m_out = 1'b1;
                end else if (m_out) begin
                    if (imem_rvalid) begin
                        m_ir    = imem_rdata;
                        m_ir_pc = m_pc;
                        m_pc    = m_pc + 32'd4;
                        m_irv   = 1'b1;
                        m_out   = 1'b0;
                    end
                end else if (m_irv) begin
                    if (ir_ready) begin
                        m_irv = 1'b0;
                        m_req = 1'b1;
                    end
                end else if (m_drop) begin
                    if (imem_rvalid) begin
                        m_drop = 1'b0;
                        m_req  = 1'b1;
                    end
                end
            end
        end
    end

    // Per-cycle compare against the model
    initial begin
        forever begin
            @(negedge CLK);
            chk("imem_req", {31'd0, imem_req}, {31'd0, m_req});
            chk("imem_addr", imem_addr, m_pc);
            chk("ir_valid", {31'd0, ir_valid}, {31'd0, m_irv});
            chk("ir", ir, m_ir);
            chk("ir_pc", ir_pc, m_ir_pc);
`ifdef FETCH_ALIGN_CHK_EN
            chk("misalign", {31'd0, misalign}, {31'd0, m_mis});
`endif
        end
    end

    // Memory responder: fixed latency, one response per request
    initial begin
        int          cd;
        logic [31:0] paddr;
        cd = 0;
        paddr = 32'h0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        forever begin
            @(negedge CLK);
            imem_rvalid = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_word(paddr);
                end
            end
            if (imem_req) begin
                cd    = lat;
                paddr = imem_addr;
            end
        end
    end

    task automatic step();
        @(negedge CLK);
    endtask

    task automatic wait_irv(input string nm);
        int n = 0;
        while (!m_irv && n < 40) begin
            step();
            n++;
        end
        if (!m_irv) begin
            vecs++; errs++;
            $display("FAIL %s: timeout waiting for ir_valid", nm);
        end
    endtask

    task automatic wait_out(input string nm);
        int n = 0;
        while (!m_out && n < 40) begin
            step();
            n++;
        end
        if (!m_out) begin
            vecs++; errs++;
            $display("FAIL %s: timeout waiting for outstanding request", nm);
        end
    endtask

    task automatic redirect(input logic [31:0] tgt);
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        step();
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
    endtask

    initial begin
        int nreq;
        RST_N = 1'b0;
        ir_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        repeat (3) step();
        chk("rst_ir_valid", {31'd0, ir_valid}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0000_0000);
        RST_N = 1'b1;

        // First fetch after reset
        step();
        chk("first_req", {31'd0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'h0000_0000);
        step();
        step();
        chk("first_irv", {31'd0, ir_valid}, 32'd1);
        chk("first_ir", ir, 32'h0050_0093);
        chk("first_ir_pc", ir_pc, 32'h0000_0000);
        step();
        chk("second_req", {31'd0, imem_req}, 32'd1);
        chk("second_addr", imem_addr, 32'h0000_0004);

        // Backpressure holds ir and suppresses requests
        ir_ready = 1'b0;
        wait_irv("stall");
        chk("stall_ir", ir, 32'h0000_0004 ^ 32'h1357_9BDF);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_hold_ir", ir, 32'h1357_9BDB);
            chk("stall_hold_pc", ir_pc, 32'h0000_0004);
            chk("stall_no_req", {31'd0, imem_req}, 32'd0);
        end
        ir_ready = 1'b1;
        lat = 3;
        step();
        chk("release_req", {31'd0, imem_req}, 32'd1);
        chk("release_addr", imem_addr, 32'h0000_0008);

        // Redirect while waiting; late response must be drained
        wait_out("drain");
        redirect(32'h0000_0100);
        lat = 1;
        chk("drain_no_req", {31'd0, imem_req}, 32'd0);
        step();
        step();
        chk("drain_req", {31'd0, imem_req}, 32'd1);
        chk("drain_addr", imem_addr, 32'h0000_0100);
        wait_irv("drain_fetch");
        chk("drain_ir", ir, mem_word(32'h0000_0100));
        chk("drain_ir_pc", ir_pc, 32'h0000_0100);
        step();

        // Redirect coincident with the response
        wait_out("coinc");
        redirect(32'h0000_0200);
        chk("coinc_irv", {31'd0, ir_valid}, 32'd0);
        chk("coinc_req", {31'd0, imem_req}, 32'd1);
        chk("coinc_addr", imem_addr, 32'h0000_0200);
        wait_irv("coinc_fetch");
        chk("coinc_ir_pc", ir_pc, 32'h0000_0200);

        // Redirect during a FULL handshake, then wrap at the top of memory
        redirect(32'hFFFF_FFFC);
        chk("wrap_irv", {31'd0, ir_valid}, 32'd0);
        chk("wrap_req_addr", imem_addr, 32'hFFFF_FFFC);
        wait_irv("wrap_fetch");
        chk("wrap_ir_pc", ir_pc, 32'hFFFF_FFFC);
        chk("wrap_next_addr", imem_addr, 32'h0000_0000);
        step();
        chk("wrap_req", {31'd0, imem_req}, 32'd1);
        wait_irv("wrap_zero");

        // Misaligned redirect target
        lat = 2;
        redirect(32'h0000_0102);
        chk("mis_req", {31'd0, imem_req}, 32'd1);
`ifdef FETCH_ALIGN_CHK_EN
        chk("mis_pulse", {31'd0, misalign}, 32'd1);
        chk("mis_addr", imem_addr, 32'h0000_0004);
        step();
        chk("mis_pulse_end", {31'd0, misalign}, 32'd0);
`else
        chk("mis_addr", imem_addr, 32'h0000_0100);
`endif

        // Reset mid-request, stale response arrives in BOOT
        wait_out("rst_mid");
        #2 RST_N = 1'b0;
        #1;
        chk("amid_req", {31'd0, imem_req}, 32'd0);
        chk("amid_addr", imem_addr, RST_PC);
        chk("amid_irv", {31'd0, ir_valid}, 32'd0);
        chk("amid_ir", ir, 32'h0);
        chk("amid_ir_pc", ir_pc, 32'h0);
        lat = 1;
        step();
        RST_N = 1'b1;
        step();
        chk("reboot_req", {31'd0, imem_req}, 32'd1);
        chk("reboot_addr", imem_addr, 32'h0000_0000);
        wait_irv("reboot_fetch");
        chk("reboot_ir", ir, 32'h0050_0093);

        // Throughput: one request every three cycles
        step();
        chk("tp_start", {31'd0, imem_req}, 32'd1);
        nreq = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (imem_req) nreq++;
        end
        chk("tp_count", nreq, 32'd4);

        step();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
